card_sequencer: RTL and testbench

CARD_SEQUENCER -- requirements
Module: card_sequencer

---
 rtl/card_sequencer.sv | 146 ++++++++++++++
 tb/tb_card_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/card_sequencer.sv
// Baccarat card-dealing sequencer: steps the datapath through the deal and third-card draws, then lights the winner.
// Optional NATURAL_CHECK_EN: when defined, a natural (8 or 9) on the first two cards skips straight to settlement.
module card_sequencer (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic [3:0] state_out
);
    localparam int unsigned STATE_W = 4;
    localparam int unsigned LOAD_W  = 6;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 4'd0,
        DEAL_P1 = 4'd1,
        DEAL_D1 = 4'd2,
        DEAL_P2 = 4'd3,
        DEAL_D2 = 4'd4,
        EVAL_P  = 4'd5,
        DEAL_P3 = 4'd6,
        EVAL_D  = 4'd7,
        DEAL_D3 = 4'd8,
        SETTLE  = 4'd9,
        DONE    = 4'd10
    } state_e;

    state_e              state_q, state_d;
    logic                pdrew_q, pdrew_d;
    logic [LOAD_W-1:0]   load_q, load_d;   // {d3, p3, d2, p2, d1, p1}
    logic                player_q, player_d;
    logic                dealer_q, dealer_d;
    logic                natural_c;
    logic                dealer_draw_c;

    always_comb begin
`ifdef NATURAL_CHECK_EN
        natural_c = (pscore >= 4'd8) || (dscore >= 4'd8);
`else
        natural_c = 1'b0;
`endif
    end

    // Dealer third-card rule; once the player has drawn it depends on the player's third card.
    always_comb begin
        dealer_draw_c = 1'b0;
        if (!pdrew_q) begin
            dealer_draw_c = (dscore <= 4'd5);
        end else begin
            case (dscore)
                4'd0, 4'd1, 4'd2: dealer_draw_c = 1'b1;
                4'd3:             dealer_draw_c = (pcard3 != 4'd8);
                4'd4:             dealer_draw_c = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
                4'd5:             dealer_draw_c = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
                4'd6:             dealer_draw_c = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
                default:          dealer_draw_c = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        pdrew_d  = pdrew_q;
        player_d = 1'b0;
        dealer_d = 1'b0;
        load_d   = '0;
        case (state_q)
            IDLE: begin
                state_d = DEAL_P1;
                pdrew_d = 1'b0;
            end
            DEAL_P1: state_d = DEAL_D1;
            DEAL_D1: state_d = DEAL_P2;
            DEAL_P2: state_d = DEAL_D2;
            DEAL_D2: state_d = EVAL_P;
            EVAL_P: begin
                if (natural_c)             state_d = SETTLE;
                else if (pscore <= 4'd5)   state_d = DEAL_P3;
                else                       state_d = EVAL_D;
            end
            DEAL_P3: begin
                pdrew_d = 1'b1;
                state_d = EVAL_D;
            end
            EVAL_D:  state_d = dealer_draw_c ? DEAL_D3 : SETTLE;
            DEAL_D3: state_d = SETTLE;
            SETTLE: begin
                state_d  = DONE;
                player_d = (pscore >= dscore);
                dealer_d = (dscore >= pscore);
            end
            DONE: begin
                state_d  = DONE;
                player_d = player_q;
                dealer_d = dealer_q;
            end
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the next state so each is high exactly while in its deal state.
        case (state_d)
            DEAL_P1: load_d[0] = 1'b1;
            DEAL_D1: load_d[1] = 1'b1;
            DEAL_P2: load_d[2] = 1'b1;
            DEAL_D2: load_d[3] = 1'b1;
            DEAL_P3: load_d[4] = 1'b1;
            DEAL_D3: load_d[5] = 1'b1;
            default: load_d    = '0;
        endcase
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q  <= IDLE;
            pdrew_q  <= 1'b0;
            load_q   <= '0;
            player_q <= 1'b0;
            dealer_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pdrew_q  <= pdrew_d;
            load_q   <= load_d;
            player_q <= player_d;
            dealer_q <= dealer_d;
        end
    end

    assign load_pcard1      = load_q[0];
    assign load_dcard1      = load_q[1];
    assign load_pcard2      = load_q[2];
    assign load_dcard2      = load_q[3];
    assign load_pcard3      = load_q[4];
    assign load_dcard3      = load_q[5];
    assign player_win_light = player_q;
    assign dealer_win_light = dealer_q;
    assign state_out        = state_q;

endmodule

// File: tb/tb_card_sequencer.sv
// Self-checking bench for card_sequencer: a hand-level baccarat model predicts the state trace and lights per cycle.
module tb_card_sequencer;
    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic [3:0] pscore     = 4'd0;
    logic [3:0] dscore     = 4'd0;
    logic [3:0] pcard3     = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;
    logic [3:0] state_out;
    logic [5:0] dut_ld;

`ifdef NATURAL_CHECK_EN
    localparam bit NAT_EN = 1'b1;
`else
    localparam bit NAT_EN = 1'b0;
`endif

    card_sequencer dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .state_out        (state_out)
    );

    always #5 slow_clock = ~slow_clock;

    assign dut_ld = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};

    int n_tests   = 0;
    int n_fail    = 0;
    int exp_state = 0;
    bit exp_pl    = 1'b0;
    bit exp_dl    = 1'b0;
    bit chk_en    = 1'b0;

    // Which card a deal state loads: {d3, p3, d2, p2, d1, p1}.
    function automatic logic [5:0] strobes_for(input int s);
        logic [5:0] v;
        v = 6'b0;
        if (s == 1) v[0] = 1'b1;
        if (s == 2) v[1] = 1'b1;
        if (s == 3) v[2] = 1'b1;
        if (s == 4) v[3] = 1'b1;
        if (s == 6) v[4] = 1'b1;
        if (s == 8) v[5] = 1'b1;
        return v;
    endfunction

    // Baccarat dealer tableau when the player took a third card.
    function automatic bit tableau_draw(input int d, input int c);
        if (d <= 2) return 1'b1;
        if (d == 3) return c != 8;
        if (d == 4) return c >= 2 && c <= 7;
        if (d == 5) return c >= 4 && c <= 7;
        if (d == 6) return c >= 6 && c <= 7;
        return 1'b0;
    endfunction

    always @(negedge slow_clock) begin
        if (chk_en) begin
            n_tests++;
            if (state_out !== 4'(exp_state) || dut_ld !== strobes_for(exp_state) ||
                player_win_light !== exp_pl || dealer_win_light !== exp_dl) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t state=%0d want %0d strobes=%b want %b lights=%b%b want %b%b",
                         $time, state_out, exp_state, dut_ld, strobes_for(exp_state),
                         player_win_light, dealer_win_light, exp_pl, exp_dl);
            end
        end
    end

    task automatic check(input string name, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic reset_pulse(input int p, input int d, input int c);
        @(negedge slow_clock);
        #1;
        resetb    = 1'b0;
        exp_state = 0;
        exp_pl    = 1'b0;
        exp_dl    = 1'b0;
        pscore    = 4'(p);
        dscore    = 4'(d);
        pcard3    = 4'(c);
        @(negedge slow_clock);
        #1;
        resetb = 1'b1;
    endtask

    // Plays one hand: p/d are scores at EVAL_P, pn/dn the scores after the third cards land.
    task automatic run_hand(input string name, input int p, input int d, input int c,
                            input int pn, input int dn, input int lit_edges,
                            input bit lit_pl, input bit lit_dl);
        int trace[$];
        bit pdraw, ddraw;
        int pf, df, done_edge, prev, e;
        trace = '{1, 2, 3, 4, 5};
        pdraw = 1'b0;
        ddraw = 1'b0;
        if (NAT_EN && (p >= 8 || d >= 8)) begin
            trace.push_back(9);
        end else begin
            pdraw = (p <= 5);
            if (pdraw) trace.push_back(6);
            trace.push_back(7);
            ddraw = pdraw ? tableau_draw(d, c) : (d <= 5);
            if (ddraw) trace.push_back(8);
            trace.push_back(9);
        end
        trace.push_back(10);
        pf = pdraw ? pn : p;
        df = ddraw ? dn : d;

        reset_pulse(p, d, c);
        done_edge = -1;
        e = 0;
        repeat (trace.size() + 3) begin
            @(posedge slow_clock);
            #1;
            e++;
            prev = exp_state;
            exp_state = (e <= trace.size()) ? trace[e-1] : 10;
            if (exp_state == 10) begin
                exp_pl = (pf >= df);
                exp_dl = (df >= pf);
            end
            if (prev == 6) pscore = 4'(pn);
            if (prev == 8) dscore = 4'(dn);
            if (done_edge < 0 && state_out == 4'd10) done_edge = e;
        end
        check({name, "_done_edge"}, done_edge, trace.size());
        check({name, "_done_edge_lit"}, done_edge, lit_edges);
        check({name, "_player_lit"}, int'(player_win_light), int'(lit_pl));
        check({name, "_dealer_lit"}, int'(dealer_win_light), int'(lit_dl));
    endtask

    task automatic reset_mid_hand();
        reset_pulse(1, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge slow_clock);
            #1;
            exp_state = k;
        end
        check("p2_strobe_before_rst", int'(load_pcard2), 1);
        #2;
        resetb    = 1'b0;
        exp_state = 0;
        #1;
        check("rst_async_load_pcard2", int'(load_pcard2), 0);
        check("rst_async_state", int'(state_out), 0);
        @(negedge slow_clock);
        #1;
        resetb = 1'b1;
        @(posedge slow_clock);
        #1;
        exp_state = 1;
        check("restart_load_pcard1", int'(load_pcard1), 1);
        check("restart_state", int'(state_out), 1);
        @(posedge slow_clock);
        #1;
        exp_state = 2;
    endtask

    initial begin
        #1;
        chk_en = 1'b1;
        check("reset_state", int'(state_out), 0);
        check("reset_strobes", int'(dut_ld), 0);
        @(negedge slow_clock);

        run_hand("nat_p8_d3",     8,  3,  0, 8, 3, NAT_EN ? 7 : 9, 1'b1, 1'b0);
        run_hand("both_draw",     4,  5,  6, 7, 9, 10,             1'b0, 1'b1);
        run_hand("stand_tie_6_6", 6,  6,  0, 6, 6, 8,              1'b1, 1'b1);
        run_hand("pc3_8_stand",   2,  3,  8, 2, 3, 9,              1'b0, 1'b1);
        run_hand("nat_p9_d0",     9,  0,  0, 9, 5, NAT_EN ? 7 : 9, 1'b1, 1'b0);
        run_hand("over_range",   12, 15,  0, 12, 15, NAT_EN ? 7 : 8, 1'b0, 1'b1);
        run_hand("pc3_15_tie",    3,  4, 15, 4, 4, 9,              1'b1, 1'b1);
        run_hand("d5_pc3_3",      5,  5,  3, 9, 5, 9,              1'b1, 1'b0);
        reset_mid_hand();
        run_hand("after_rst",     6,  7,  0, 6, 7, 8,              1'b0, 1'b1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
